// File: rtl/column_compressor_if.sv
// Column/result bundle for column_compressor: 15 columns of 15 equal-weight bits in,
// 20 single-bit result ports out.
interface column_compressor_if;
  logic [14:0] src0, src1, src2, src3, src4, src5, src6, src7;
  logic [14:0] src8, src9, src10, src11, src12, src13, src14;
  logic dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9;
  logic dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19;

  modport master (
    output src0, src1, src2, src3, src4, src5, src6, src7,
           src8, src9, src10, src11, src12, src13, src14,
    input  dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9,
           dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19
  );

  modport slave (
    input  src0, src1, src2, src3, src4, src5, src6, src7,
           src8, src9, src10, src11, src12, src13, src14,
    output dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9,
           dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19
  );
endinterface

// File: rtl/column_compressor.sv
// Weighted bit-column compressor: carry-save full-adder tree + final CPA into a 20-bit register.
// Define COMPRESSOR_IN_REG_EN to add a reset-to-zero input register stage (latency 2 instead of 1).
module column_compressor #(
    parameter int NCOL  = 15,
    parameter int NROW  = 15,
    parameter int OUT_W = 20
) (
    input logic           clk,
    input logic           rst_n,
    column_compressor_if.slave cif
);

    // Worst-case column height after the first reduction level is 10; 16 leaves headroom.
    localparam int MAXH   = 16;
    localparam int MAXR   = 4;
    localparam int STAGES = 8;

    logic [NCOL-1:0][NROW-1:0] src_p;
    logic [NCOL-1:0][NROW-1:0] src_t;
    logic [OUT_W-1:0]          tree_sum;
    logic [OUT_W-1:0]          res_q;

    assign src_p = {cif.src14, cif.src13, cif.src12, cif.src11, cif.src10,
                    cif.src9,  cif.src8,  cif.src7,  cif.src6,  cif.src5,
                    cif.src4,  cif.src3,  cif.src2,  cif.src1,  cif.src0};

`ifdef COMPRESSOR_IN_REG_EN
    logic [NCOL-1:0][NROW-1:0] src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_q <= '0;
        else        src_q <= src_p;
    end

    assign src_t = src_q;
`else
    assign src_t = src_p;
`endif

    // Each level folds bit triples of any column taller than 3 into a sum (same column)
    // and a carry (next column); columns of height <= 3 pass through untouched.
    always_comb begin : tree
        logic cur [OUT_W][MAXH];
        logic nxt [OUT_W][MAXH];
        int   ch  [OUT_W];
        int   nh  [OUT_W];
        int   nfa;
        logic a, b, d;
        logic [OUT_W-1:0] rows [MAXR];

        nfa = 0;
        a = 1'b0;
        b = 1'b0;
        d = 1'b0;
        for (int c = 0; c < OUT_W; c++) begin
            ch[c] = 0;
            nh[c] = 0;
            for (int k = 0; k < MAXH; k++) begin
                cur[c][k] = 1'b0;
                nxt[c][k] = 1'b0;
            end
        end
        for (int c = 0; c < NCOL; c++) begin
            ch[c] = NROW;
            for (int k = 0; k < NROW; k++) cur[c][k] = src_t[c][k];
        end

        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < OUT_W; c++) begin
                nh[c] = 0;
                for (int k = 0; k < MAXH; k++) nxt[c][k] = 1'b0;
            end
            for (int c = 0; c < OUT_W; c++) begin
                nfa = (ch[c] > 3) ? ch[c] / 3 : 0;
                for (int k = 0; k < MAXH / 3; k++) begin
                    if (k < nfa) begin
                        a = cur[c][3*k];
                        b = cur[c][3*k+1];
                        d = cur[c][3*k+2];
                        nxt[c][nh[c]] = a ^ b ^ d;
                        nh[c] = nh[c] + 1;
                        // Top-column carries are provably zero (max sum fits in OUT_W bits).
                        if (c + 1 < OUT_W) begin
                            nxt[c+1][nh[c+1]] = (a & b) | (a & d) | (b & d);
                            nh[c+1] = nh[c+1] + 1;
                        end
                    end
                end
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= 3 * nfa && k < ch[c]) begin
                        nxt[c][nh[c]] = cur[c][k];
                        nh[c] = nh[c] + 1;
                    end
                end
            end
            for (int c = 0; c < OUT_W; c++) begin
                ch[c] = nh[c];
                for (int k = 0; k < MAXH; k++) cur[c][k] = nxt[c][k];
            end
        end

        // Remaining (at most 3 deep) columns are laid out as rows for the carry-propagate add.
        for (int r = 0; r < MAXR; r++) begin
            rows[r] = '0;
            for (int c = 0; c < OUT_W; c++) rows[r][c] = (r < ch[c]) ? cur[c][r] : 1'b0;
        end
        tree_sum = rows[0] + rows[1] + rows[2] + rows[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= tree_sum;
    end

    assign cif.dst0  = res_q[0];
    assign cif.dst1  = res_q[1];
    assign cif.dst2  = res_q[2];
    assign cif.dst3  = res_q[3];
    assign cif.dst4  = res_q[4];
    assign cif.dst5  = res_q[5];
    assign cif.dst6  = res_q[6];
    assign cif.dst7  = res_q[7];
    assign cif.dst8  = res_q[8];
    assign cif.dst9  = res_q[9];
    assign cif.dst10 = res_q[10];
    assign cif.dst11 = res_q[11];
    assign cif.dst12 = res_q[12];
    assign cif.dst13 = res_q[13];
    assign cif.dst14 = res_q[14];
    assign cif.dst15 = res_q[15];
    assign cif.dst16 = res_q[16];
    assign cif.dst17 = res_q[17];
    assign cif.dst18 = res_q[18];
    assign cif.dst19 = res_q[19];

endmodule

// File: tb/tb_column_compressor.sv
// Bench for column_compressor: popcount-weighted reference delayed by the latency, checked
// every cycle, plus literal-value directed vectors and an asynchronous mid-stream reset.
module tb_column_compressor;
`ifdef COMPRESSOR_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] src [15];
  logic [19:0] dst_v;
  int          exp_pipe [LAT];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          en_cmp = 1'b0;

  column_compressor_if cif ();

  column_compressor dut (.clk(clk), .rst_n(rst_n), .cif(cif.slave));

  always #5 clk = ~clk;

  assign cif.src0  = src[0];
  assign cif.src1  = src[1];
  assign cif.src2  = src[2];
  assign cif.src3  = src[3];
  assign cif.src4  = src[4];
  assign cif.src5  = src[5];
  assign cif.src6  = src[6];
  assign cif.src7  = src[7];
  assign cif.src8  = src[8];
  assign cif.src9  = src[9];
  assign cif.src10 = src[10];
  assign cif.src11 = src[11];
  assign cif.src12 = src[12];
  assign cif.src13 = src[13];
  assign cif.src14 = src[14];
  assign dst_v = {cif.dst19, cif.dst18, cif.dst17, cif.dst16, cif.dst15,
                  cif.dst14, cif.dst13, cif.dst12, cif.dst11, cif.dst10,
                  cif.dst9,  cif.dst8,  cif.dst7,  cif.dst6,  cif.dst5,
                  cif.dst4,  cif.dst3,  cif.dst2,  cif.dst1,  cif.dst0};

  function automatic int model_sum();
    int r = 0;
    for (int i = 0; i < 15; i++) r += $countones(src[i]) << i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input int expv);
    n_cmp++;
    if (got !== 20'(expv)) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, got, 20'(expv));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [14:0] v);
    for (int i = 0; i < 15; i++) src[i] = v;
  endtask

  // Reference: the weighted sum of whatever is on the ports at each edge, delayed LAT edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LAT; j++) exp_pipe[j] <= 0;
    end else begin
      for (int j = LAT - 1; j > 0; j--) exp_pipe[j] <= exp_pipe[j-1];
      exp_pipe[0] <= model_sum();
    end
  end

  always @(negedge clk) begin
    if (en_cmp) chk("stream", dst_v, exp_pipe[LAT-1]);
  end

  initial begin
    for (int j = 0; j < LAT; j++) exp_pipe[j] = 0;
    set_all(15'h7FFF);
    rst_n = 1'b0;
    step();
    step();
    chk("reset_hold", dst_v, 0);
    en_cmp = 1'b1;
    #2 rst_n = 1'b1;
    repeat (LAT) step();
    chk("all_ones", dst_v, 32'h77FF1);

    // Back-to-back: column 0 full, then lone bit in column 14.
    set_all('0); src[0] = 15'h7FFF;
    step();
    set_all('0); src[14] = 15'h0001;
    repeat (LAT - 1) step();
    chk("col0_full", dst_v, 15);
    step();
    chk("col14_bit0", dst_v, 16384);

    for (int i = 0; i < 15; i++) src[i] = 15'(1 << i);
    repeat (LAT) step();
    chk("diag", dst_v, 32767);
    for (int i = 0; i < 15; i++) src[i] = 15'(1 << (14 - i));
    repeat (LAT) step();
    chk("anti_diag", dst_v, 32767);

    set_all('0); src[5] = 15'h0003; src[6] = 15'h0001;
    repeat (LAT) step();
    chk("carry_ripple", dst_v, 128);

    set_all('0); src[3] = 15'h0007; src[10] = 15'h7FFF;
    repeat (LAT) step();
    chk("mixed", dst_v, 3 * 8 + 15 * 1024);

    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 15; i++) src[i] = 15'($urandom);
      if (n % 1000 == 500) begin
        // Reset dropped between edges while streaming nonzero data.
        #2 rst_n = 1'b0;
        #1 chk("async_rst", dst_v, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end else begin
        step();
      end
    end

    set_all('0);
    repeat (LAT + 1) step();
    chk("drain_zero", dst_v, 0);
    en_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
